// File: rtl/jericalla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jericalla_pkg
// Description : Opcodes, instruction field layout and decode helpers shared by
//               the Jericalla pipeline core.
// Revision    : 1.0
// ============================================================================
package jericalla_pkg;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_ADD   = 3'd0;
    localparam logic [OPC_W-1:0] OP_SUB   = 3'd1;
    localparam logic [OPC_W-1:0] OP_AND   = 3'd2;
    localparam logic [OPC_W-1:0] OP_OR    = 3'd3;
    localparam logic [OPC_W-1:0] OP_SLT   = 3'd4;
    localparam logic [OPC_W-1:0] OP_LOAD  = 3'd5;
    localparam logic [OPC_W-1:0] OP_STORE = 3'd6;
    localparam logic [OPC_W-1:0] OP_NOP   = 3'd7;

    // Field positions in units of REG_ADDR_W, counted from the LSB: {op, rd, rs1, rs2}
    localparam int RS2_FIELD = 0;
    localparam int RS1_FIELD = 1;
    localparam int RD_FIELD  = 2;
    localparam int OP_FIELD  = 3;

    function automatic logic op_writes_reg(input logic [OPC_W-1:0] op);
        return (op <= OP_LOAD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jericalla_regfile.sv
`default_nettype none
// ============================================================================
// Module      : jericalla_regfile
// Description : Register file, two asynchronous read ports, one synchronous
//               write port, asynchronous clear; r0 always reads as zero.
// Revision    : 1.0
// ============================================================================
module jericalla_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    localparam int c_num_regs = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [0:c_num_regs-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_num_regs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/jericalla_pipe.sv
`default_nettype none
// ============================================================================
// Module      : jericalla_pipe
// Description : Three-stage (ID/EX/WB) execution core with valid/ready issue,
//               operand bypass, load-use interlock and inline data memory.
// Revision    : 1.0
// ============================================================================
module jericalla_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MEM_ADDR_W = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [3+3*REG_ADDR_W-1:0] instruction,
    output logic                      result_valid,
    output logic [REG_ADDR_W-1:0]     result_rd,
    output logic [DATA_W-1:0]         result_out
);

    import jericalla_pkg::*;

    localparam int c_rs2_lsb = RS2_FIELD * REG_ADDR_W;
    localparam int c_rs1_lsb = RS1_FIELD * REG_ADDR_W;
    localparam int c_rd_lsb  = RD_FIELD  * REG_ADDR_W;
    localparam int c_op_lsb  = OP_FIELD  * REG_ADDR_W;

    logic [OPC_W-1:0]      w_op;
    logic [REG_ADDR_W-1:0] w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0]     w_rf_a, w_rf_b, w_opa, w_opb;
    logic                  w_accept, w_load_use, w_ex_fwd, w_wb_we;
    logic [DATA_W-1:0]     w_alu, w_wb_data;
    logic [MEM_ADDR_W-1:0] w_mem_addr;

    logic                  r_ex_valid;
    logic [OPC_W-1:0]      r_ex_op;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic [DATA_W-1:0]     r_ex_a, r_ex_b;

    logic                  r_wb_valid;
    logic [OPC_W-1:0]      r_wb_op;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [DATA_W-1:0]     r_wb_alu;

    logic [DATA_W-1:0]     r_mem [0:2**MEM_ADDR_W-1];
    logic [DATA_W-1:0]     r_mem_rdata;

    assign w_op  = instruction[c_op_lsb  +: OPC_W];
    assign w_rd  = instruction[c_rd_lsb  +: REG_ADDR_W];
    assign w_rs1 = instruction[c_rs1_lsb +: REG_ADDR_W];
    assign w_rs2 = instruction[c_rs2_lsb +: REG_ADDR_W];

    jericalla_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk       (clock),
        .rst       (reset),
        .i_raddr_a (w_rs1),
        .o_rdata_a (w_rf_a),
        .i_raddr_b (w_rs2),
        .o_rdata_b (w_rf_b),
        .i_we      (w_wb_we),
        .i_waddr   (r_wb_rd),
        .i_wdata   (w_wb_data)
    );

    // A LOAD in EX has no data yet, so it is excluded from the EX bypass and stalls instead
    assign w_ex_fwd   = r_ex_valid && op_writes_reg(r_ex_op) && (r_ex_op != OP_LOAD) && (r_ex_rd != '0);
    assign w_load_use = r_ex_valid && (r_ex_op == OP_LOAD) && (r_ex_rd != '0) &&
                        ((r_ex_rd == w_rs1) || (r_ex_rd == w_rs2));
    assign instr_ready = !w_load_use;
    assign w_accept    = instr_valid && instr_ready;

    always_comb begin
        w_opa = w_rf_a;
        if (w_rs1 == '0)                              w_opa = '0;
        else if (w_ex_fwd && (r_ex_rd == w_rs1))      w_opa = w_alu;
        else if (w_wb_we && (r_wb_rd == w_rs1))       w_opa = w_wb_data;
    end

    always_comb begin
        w_opb = w_rf_b;
        if (w_rs2 == '0)                              w_opb = '0;
        else if (w_ex_fwd && (r_ex_rd == w_rs2))      w_opb = w_alu;
        else if (w_wb_we && (r_wb_rd == w_rs2))       w_opb = w_wb_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ex_valid <= 1'b0;
            r_ex_op    <= OP_NOP;
            r_ex_rd    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
        end else begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_ex_op <= w_op;
                r_ex_rd <= w_rd;
                r_ex_a  <= w_opa;
                r_ex_b  <= w_opb;
            end
        end
    end

    always_comb begin
        w_alu = '0;
        case (r_ex_op)
            OP_ADD:  w_alu = r_ex_a + r_ex_b;
            OP_SUB:  w_alu = r_ex_a - r_ex_b;
            OP_AND:  w_alu = r_ex_a & r_ex_b;
            OP_OR:   w_alu = r_ex_a | r_ex_b;
            OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_ex_a) < $signed(r_ex_b))};
            default: w_alu = '0;
        endcase
    end

    assign w_mem_addr = r_ex_a[MEM_ADDR_W-1:0];

    // Data memory keeps its contents across reset; reset already clears r_ex_valid
    always_ff @(posedge clock) begin
        if (r_ex_valid && (r_ex_op == OP_STORE)) begin
            r_mem[w_mem_addr] <= r_ex_b;
        end
        if (r_ex_valid && (r_ex_op == OP_LOAD)) begin
            r_mem_rdata <= r_mem[w_mem_addr];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_op    <= OP_NOP;
            r_wb_rd    <= '0;
            r_wb_alu   <= '0;
        end else begin
            r_wb_valid <= r_ex_valid;
            r_wb_op    <= r_ex_op;
            r_wb_rd    <= r_ex_rd;
            r_wb_alu   <= w_alu;
        end
    end

    assign w_wb_data = (r_wb_op == OP_LOAD) ? r_mem_rdata : r_wb_alu;
    assign w_wb_we   = r_wb_valid && op_writes_reg(r_wb_op) && (r_wb_rd != '0);

    assign result_valid = w_wb_we;
    assign result_rd    = w_wb_we ? r_wb_rd   : '0;
    assign result_out   = w_wb_we ? w_wb_data : '0;

endmodule
`default_nettype wire
